// File: rtl/stream_vector_pack_if.sv
// Stream-in / wide-vector-out handshake bundle for the serial-to-parallel packer.
// The packer itself takes the slave view; whoever feeds samples and drains vectors takes master.
interface stream_vector_pack_if #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 18
);
  localparam int FILL_W = $clog2(SIZE + 1);

  logic [WIDTH-1:0]      i_tdata;
  logic                  i_tlast;
  logic                  i_tvalid;
  logic                  i_tready;
  logic [SIZE*WIDTH-1:0] o_tdata;
  logic [FILL_W-1:0]     o_tfill;
  logic                  o_tlast;
  logic                  o_tvalid;
  logic                  o_tready;

  modport master (
    output i_tdata, i_tlast, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tfill, o_tlast, o_tvalid
  );

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tfill, o_tlast, o_tvalid
  );
endinterface

// File: rtl/stream_vector_pack.sv
// Serial-to-parallel packer: SIZE samples of WIDTH bits become one zero-padded vector beat.
// Accumulator plus output register give one sample per clock while downstream keeps up.
module stream_vector_pack #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 18
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  stream_vector_pack_if.slave bus
);
  localparam int IDX_W  = $clog2(SIZE);
  localparam int FILL_W = $clog2(SIZE + 1);
  localparam int VEC_W  = SIZE * WIDTH;

  typedef enum logic {ST_FILL, ST_PEND} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [VEC_W-1:0]  acc_q, acc_d, acc_upd;
  logic              pend_last_q, pend_last_d;
  logic [VEC_W-1:0]  out_data_q, out_data_d;
  logic [FILL_W-1:0] out_fill_q, out_fill_d;
  logic              out_last_q, out_last_d;
  logic              out_vld_q, out_vld_d;

  logic              flush;
  logic              in_ready;
  logic              in_fire;
  logic              out_fire;
  logic              slot_free;
  logic              closing;
  logic [FILL_W-1:0] fill_now;

  assign flush     = reset | clear;
  // Ready comes from the registered state only; the flush gate keeps it low during reset/clear.
  assign in_ready  = (state_q == ST_FILL) & ~flush;
  assign in_fire   = bus.i_tvalid & in_ready;
  assign out_fire  = out_vld_q & bus.o_tready;
  assign slot_free = ~out_vld_q | bus.o_tready;
  assign closing   = (idx_q == IDX_W'(SIZE - 1)) | bus.i_tlast;
  assign fill_now  = FILL_W'(idx_q) + FILL_W'(1);

  always_comb begin
    acc_upd = acc_q;
    acc_upd[int'(idx_q)*WIDTH +: WIDTH] = bus.i_tdata;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    pend_last_d = pend_last_q;
    out_data_d  = out_data_q;
    out_fill_d  = out_fill_q;
    out_last_d  = out_last_q;
    out_vld_d   = out_vld_q;

    if (out_fire) begin
      out_vld_d = 1'b0;
    end

    case (state_q)
      ST_FILL: begin
        if (in_fire) begin
          if (closing && slot_free) begin
            out_data_d = acc_upd;
            out_fill_d = fill_now;
            out_last_d = bus.i_tlast;
            out_vld_d  = 1'b1;
            acc_d      = '0;
            idx_d      = '0;
          end else if (closing) begin
            // Output still held: park the finished vector; idx keeps its fill count.
            acc_d       = acc_upd;
            pend_last_d = bus.i_tlast;
            state_d     = ST_PEND;
          end else begin
            acc_d = acc_upd;
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PEND: begin
        if (out_fire) begin
          out_data_d = acc_q;
          out_fill_d = fill_now;
          out_last_d = pend_last_q;
          out_vld_d  = 1'b1;
          acc_d      = '0;
          idx_d      = '0;
          state_d    = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase

    if (flush) begin
      state_d     = ST_FILL;
      idx_d       = '0;
      acc_d       = '0;
      pend_last_d = 1'b0;
      out_data_d  = '0;
      out_fill_d  = '0;
      out_last_d  = 1'b0;
      out_vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    idx_q       <= idx_d;
    acc_q       <= acc_d;
    pend_last_q <= pend_last_d;
    out_data_q  <= out_data_d;
    out_fill_q  <= out_fill_d;
    out_last_q  <= out_last_d;
    out_vld_q   <= out_vld_d;
  end

  assign bus.i_tready = in_ready;
  assign bus.o_tdata  = out_data_q;
  assign bus.o_tfill  = out_fill_q;
  assign bus.o_tlast  = out_last_q;
  assign bus.o_tvalid = out_vld_q;
endmodule

// File: tb/tb_stream_vector_pack.sv
// Bench for stream_vector_pack: directed SIZE=4 scenarios plus a randomized SIZE=18 run,
// all checked by a packet-level reference model feeding a scoreboard.
module tb_stream_vector_pack;
  localparam int MAXW = 18 * 16;

  typedef struct packed {
    logic [MAXW-1:0] data;
    logic [4:0]      fill;
    logic            last;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic clear;

  always #5 clk = ~clk;

  stream_vector_pack_if #(.WIDTH(16), .SIZE(4))  b4 ();
  stream_vector_pack_if #(.WIDTH(16), .SIZE(18)) b18 ();

  stream_vector_pack #(.WIDTH(16), .SIZE(4)) u4 (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (b4.slave)
  );

  stream_vector_pack #(.WIDTH(16), .SIZE(18)) u18 (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (b18.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int stalls4 = 0;

  vec_t q4[$];
  vec_t q18[$];
  int          part_n[2];
  logic [15:0] part_d[2][18];

  bit              hold[2];
  logic [MAXW-1:0] hold_data[2];
  logic [4:0]      hold_fill[2];
  logic            hold_last[2];

  task automatic check(input string name, input logic [MAXW-1:0] act, input logic [MAXW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: collect accepted samples per packet, emit a padded vector when the
  // packet reaches SIZE samples or carries tlast; a flush drops everything not yet delivered.
  task automatic observe(input int inst, input int sz,
                         input logic ivld, input logic irdy, input logic [15:0] idat, input logic ilast,
                         input logic ovld, input logic ordy, input logic [MAXW-1:0] odat,
                         input logic [4:0] ofill, input logic olast, input logic rc);
    vec_t  e;
    string tag;
    int    qn;
    tag = (inst == 0) ? "s4" : "s18";
    if (hold[inst]) begin
      check({tag, " hold_valid"}, MAXW'(ovld), MAXW'(1'b1));
      check({tag, " hold_data"}, odat, hold_data[inst]);
      check({tag, " hold_fill"}, MAXW'(ofill), MAXW'(hold_fill[inst]));
      check({tag, " hold_last"}, MAXW'(olast), MAXW'(hold_last[inst]));
    end
    if (ovld === 1'b1 && ordy === 1'b1) begin
      qn = (inst == 0) ? q4.size() : q18.size();
      if (qn == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s unexpected_output: got %h expected no beat", tag, odat);
      end else begin
        if (inst == 0) e = q4.pop_front();
        else           e = q18.pop_front();
        check({tag, " out_data"}, odat, e.data);
        check({tag, " out_fill"}, MAXW'(ofill), MAXW'(e.fill));
        check({tag, " out_last"}, MAXW'(olast), MAXW'(e.last));
      end
    end
    if (ivld === 1'b1 && irdy === 1'b1) begin
      part_d[inst][part_n[inst]] = idat;
      part_n[inst]++;
      if (part_n[inst] == sz || ilast === 1'b1) begin
        e.data = '0;
        for (int k = 0; k < part_n[inst]; k++) e.data[k*16 +: 16] = part_d[inst][k];
        e.fill = 5'(part_n[inst]);
        e.last = ilast;
        if (inst == 0) q4.push_back(e);
        else           q18.push_back(e);
        part_n[inst] = 0;
      end
    end
    if (rc === 1'b1) begin
      if (inst == 0) q4.delete();
      else           q18.delete();
      part_n[inst] = 0;
    end
    hold[inst]      = (ovld === 1'b1) && (ordy === 1'b0) && (rc !== 1'b1);
    hold_data[inst] = odat;
    hold_fill[inst] = ofill;
    hold_last[inst] = olast;
  endtask

  always @(negedge clk) begin
    observe(0, 4, b4.i_tvalid, b4.i_tready, b4.i_tdata, b4.i_tlast,
            b4.o_tvalid, b4.o_tready, MAXW'(b4.o_tdata), 5'(b4.o_tfill), b4.o_tlast, reset | clear);
    observe(1, 18, b18.i_tvalid, b18.i_tready, b18.i_tdata, b18.i_tlast,
            b18.o_tvalid, b18.o_tready, MAXW'(b18.o_tdata), 5'(b18.o_tfill), b18.o_tlast, reset | clear);
  end

  task automatic send(input int inst, input logic [15:0] d, input logic l);
    logic ok;
    if (inst == 0) begin b4.i_tdata = d; b4.i_tlast = l; b4.i_tvalid = 1'b1; end
    else begin b18.i_tdata = d; b18.i_tlast = l; b18.i_tvalid = 1'b1; end
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      ok = (inst == 0) ? b4.i_tready : b18.i_tready;
      @(posedge clk);
      #1;
      if (ok === 1'b1) return;
      if (inst == 0) stalls4++;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL send_timeout: inst %0d sample %h not accepted", inst, d);
  endtask

  task automatic idle(input int inst, input int n);
    if (inst == 0) b4.i_tvalid = 1'b0;
    else           b18.i_tvalid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input bit is_reset);
    if (is_reset) reset = 1'b1;
    else          clear = 1'b1;
    @(posedge clk);
    #1;
  endtask

  bit rnd_done;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    b4.i_tdata = '0;  b4.i_tlast = 1'b0;  b4.i_tvalid = 1'b0;  b4.o_tready = 1'b1;
    b18.i_tdata = '0; b18.i_tlast = 1'b0; b18.i_tvalid = 1'b0; b18.o_tready = 1'b1;
    for (int i = 0; i < 2; i++) begin part_n[i] = 0; hold[i] = 1'b0; end

    repeat (3) @(posedge clk);
    #1;
    check("rst i_tready", MAXW'(b4.i_tready), '0);
    check("rst o_tvalid", MAXW'(b4.o_tvalid), '0);
    check("rst o_tdata",  MAXW'(b4.o_tdata), '0);
    check("rst o_tfill",  MAXW'(b4.o_tfill), '0);
    check("rst o_tlast",  MAXW'(b4.o_tlast), '0);
    reset = 1'b0;
    #1;
    check("post_rst i_tready", MAXW'(b4.i_tready), MAXW'(1'b1));

    // Full vectors back to back
    stalls4 = 0;
    for (int i = 1; i <= 8; i++) begin
      send(0, 16'(i), 1'b0);
      if (i == 4) begin
        check("t1 latency valid", MAXW'(b4.o_tvalid), MAXW'(1'b1));
        check("t1 first vector", MAXW'(b4.o_tdata), MAXW'(64'h0004_0003_0002_0001));
      end
    end
    check("t1 no stalls", MAXW'(stalls4), '0);
    idle(0, 3);

    // Short packet then next packet restarts at lane 0
    send(0, 16'hA0A0, 1'b0);
    send(0, 16'hB1B1, 1'b0);
    send(0, 16'hC2C2, 1'b1);
    check("t2 short data", MAXW'(b4.o_tdata), MAXW'(64'h0000_C2C2_B1B1_A0A0));
    check("t2 short fill", MAXW'(b4.o_tfill), MAXW'(3));
    check("t2 short last", MAXW'(b4.o_tlast), MAXW'(1'b1));
    for (int i = 0; i < 4; i++) send(0, 16'hD000 + 16'(i), 1'b0);
    check("t2 lane0 restart", MAXW'(b4.o_tdata), MAXW'(64'hD003_D002_D001_D000));
    idle(0, 3);

    // Backpressure: second vector parks, input stalls, zero-bubble reload
    b4.o_tready = 1'b0;
    for (int i = 1; i <= 8; i++) send(0, 16'(i), 1'b0);
    b4.i_tdata = 16'd9; b4.i_tlast = 1'b0; b4.i_tvalid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("t3 pend ready", MAXW'(b4.i_tready), '0);
    check("t3 held data", MAXW'(b4.o_tdata), MAXW'(64'h0004_0003_0002_0001));
    b4.o_tready = 1'b1;
    @(posedge clk);
    #1;
    check("t3 reload valid", MAXW'(b4.o_tvalid), MAXW'(1'b1));
    check("t3 reload data", MAXW'(b4.o_tdata), MAXW'(64'h0008_0007_0006_0005));
    check("t3 ready back", MAXW'(b4.i_tready), MAXW'(1'b1));
    for (int i = 9; i <= 12; i++) send(0, 16'(i), 1'b0);
    idle(0, 3);

    // clear discards a partial vector, then a pending one
    send(0, 16'd1, 1'b0);
    send(0, 16'd2, 1'b0);
    b4.i_tvalid = 1'b0;
    pulse(1'b0);
    clear = 1'b0;
    for (int i = 9; i <= 12; i++) send(0, 16'(i), 1'b0);
    check("t4 after clear", MAXW'(b4.o_tdata), MAXW'(64'h000C_000B_000A_0009));
    idle(0, 3);
    b4.o_tready = 1'b0;
    for (int i = 1; i <= 8; i++) send(0, 16'(i), 1'b0);
    b4.i_tvalid = 1'b0;
    pulse(1'b0);
    clear = 1'b0;
    check("t4 clear pend valid", MAXW'(b4.o_tvalid), '0);
    b4.o_tready = 1'b1;
    idle(0, 5);
    check("t4 nothing emitted", MAXW'(b4.o_tvalid), '0);

    // reset with a vector held and a partial one in flight
    b4.o_tready = 1'b0;
    for (int i = 1; i <= 6; i++) send(0, 16'(i), 1'b0);
    b4.i_tvalid = 1'b0;
    pulse(1'b1);
    check("t5 rst valid", MAXW'(b4.o_tvalid), '0);
    check("t5 rst data", MAXW'(b4.o_tdata), '0);
    check("t5 rst fill", MAXW'(b4.o_tfill), '0);
    check("t5 rst last", MAXW'(b4.o_tlast), '0);
    reset = 1'b0;
    b4.o_tready = 1'b1;
    #1;
    check("t5 ready after rst", MAXW'(b4.i_tready), MAXW'(1'b1));
    for (int i = 7; i <= 10; i++) send(0, 16'(i), 1'b0);
    check("t5 lane0 after rst", MAXW'(b4.o_tdata), MAXW'(64'h000A_0009_0008_0007));
    idle(0, 4);

    // Randomized SIZE=18 traffic, tlast every 7 samples
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 196; i++) begin
          while ($urandom_range(0, 9) < 3) idle(1, 1);
          send(1, 16'($urandom), (i % 7) == 6);
        end
        b18.i_tvalid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          b18.o_tready = ($urandom_range(0, 9) < 6);
        end
      end
    join
    b18.o_tready = 1'b1;
    for (int c = 0; c < 300 && q18.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    idle(1, 3);
    check("rnd drained", MAXW'(q18.size()), '0);
    check("rnd no partial", MAXW'(part_n[1]), '0);
    check("rnd idle valid", MAXW'(b18.o_tvalid), '0);
    check("s4 drained", MAXW'(q4.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
